// File: rtl/gost89_ecb_core_if.sv
// ---------------------------------------------------------------------------
// gost89_ecb_core_if
//
// Bundles the block-level handshake and data buses of gost89_ecb_core.
//
// Signals:
//   in_valid  - producer offers a block
//   in_ready  - core can take a block this cycle
//   in_mode   - 1 = decrypt, 0 = encrypt
//   in_key    - 256-bit key, K0 in the top 32 bits, K7 in the bottom 32 bits
//   in_sbox   - 512-bit S-box table (8 boxes x 16 entries x 4 bits)
//   in_data   - 64-bit block, N1 in the top half, N2 in the bottom half
//   out_valid - result block available
//   out_ready - consumer takes the result
//   out_data  - 64-bit result block
//   busy      - rounds are being computed
//
// Modports:
//   slave  - the cipher core side
//   master - the side that feeds blocks and collects results
// ---------------------------------------------------------------------------
interface gost89_ecb_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [255:0] in_key;
    logic [511:0] in_sbox;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_mode, in_key, in_sbox, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_mode, in_key, in_sbox, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/gost89_ecb_core.sv
// ---------------------------------------------------------------------------
// gost89_ecb_core
//
// GOST 28147-89 ECB engine. One 64-bit block is encrypted or decrypted per
// transaction; UNROLL rounds are evaluated per clock, so a block takes
// 32/UNROLL cycles from accept to result. Key, S-box and direction are
// captured when the block is accepted, so the caller may change them freely
// while the block is in flight.
//
// Parameters:
//   UNROLL - rounds per clock: 1, 2, 4, 8, 16 or 32
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high; aborts any block in progress
//   bus   - gost89_ecb_core_if.slave (input/output handshakes, data, busy)
//
// S-box table layout (shared with gost89_round): box i substitutes nibble i
// of the 32-bit word (nibble 0 = bits 3:0) and occupies in_sbox[64*i +: 64];
// entry v of that box is at in_sbox[64*i + 4*v +: 4].
// ---------------------------------------------------------------------------

// One Feistel round: N1' = N2 ^ f(N1 + K), N2' = N1, where f is the eight
// 4-bit substitutions followed by a rotate left by 11.
module gost89_round (
    input  logic [31:0]  n1_i,
    input  logic [31:0]  n2_i,
    input  logic [31:0]  key_i,
    input  logic [511:0] sbox_i,
    output logic [31:0]  n1_o,
    output logic [31:0]  n2_o
);
    logic [31:0] sum;
    logic [31:0] subst;

    // Modular add with the round key, then substitute each nibble through
    // its own S-box.
    always_comb begin
        sum   = n1_i + key_i;
        subst = '0;
        for (int i = 0; i < 8; i++) begin
            subst[4*i +: 4] = sbox_i[64*i + int'({sum[4*i +: 4], 2'b00}) +: 4];
        end
    end

    assign n1_o = n2_i ^ {subst[20:0], subst[31:21]};
    assign n2_o = n1_i;
endmodule

module gost89_ecb_core #(
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    gost89_ecb_core_if.slave bus
);
    localparam bit LEGAL_UNROLL = (UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4) ||
                                  (UNROLL == 8) || (UNROLL == 16) || (UNROLL == 32);
    localparam int NCYC  = (UNROLL > 0 && UNROLL <= 32) ? 32 / UNROLL : 1;
    localparam int LOG_U = (UNROLL > 1) ? $clog2(UNROLL) : 0;
    localparam int CW    = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!LEGAL_UNROLL) begin : gBadUnroll
        $error("gost89_ecb_core: UNROLL must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [31:0]    n1_q,    n1_d;
    logic [31:0]    n2_q,    n2_d;
    logic           mode_q,  mode_d;
    logic [255:0]   key_q,   key_d;
    logic [511:0]   sbox_q,  sbox_d;
    logic [63:0]    out_q,   out_d;

    logic           accept;
    logic           lastCycle;
    logic [4:0]     baseRound;
    logic [31:0]    chainN1 [UNROLL+1];
    logic [31:0]    chainN2 [UNROLL+1];

    // A finished block can be drained and a new one taken on the same edge,
    // so ready looks at out_ready in DONE but never at in_valid.
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_data  = out_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign lastCycle = (cnt_q == CW'(NCYC - 1));

    // First round handled this cycle; the low LOG_U bits are always zero so
    // the per-stage offset can simply be OR-ed in.
    assign baseRound = 5'(cnt_q) << LOG_U;

    assign chainN1[0] = n1_q;
    assign chainN2[0] = n2_q;

    // Unrolled round chain. Encryption walks the key forward for rounds
    // 0..23 and backward for 24..31; decryption walks forward only for 0..7.
    // A backward index 7-(r%8) is just the bitwise inverse of r[2:0], and
    // key word i lives at key_q[32*(7-i) +: 32].
    for (genvar u = 0; u < UNROLL; u++) begin : gRound
        logic [4:0] roundIdx;
        logic       forwardKey;
        logic [2:0] keyIdx;

        assign roundIdx   = baseRound | 5'(u);
        assign forwardKey = mode_q ? (roundIdx < 5'd8) : (roundIdx < 5'd24);
        assign keyIdx     = forwardKey ? roundIdx[2:0] : ~roundIdx[2:0];

        gost89_round uRound (
            .n1_i   (chainN1[u]),
            .n2_i   (chainN2[u]),
            .key_i  (key_q[{~keyIdx, 5'b00000} +: 32]),
            .sbox_i (sbox_q),
            .n1_o   (chainN1[u+1]),
            .n2_o   (chainN2[u+1])
        );
    end

    // Next-state logic. The last round does not swap halves, so the result
    // is the chain output with its two halves exchanged back, written
    // straight into the output register. An accept overrides whatever the
    // DONE branch decided, which gives the same-edge drain-and-reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        mode_d  = mode_q;
        key_d   = key_q;
        sbox_d  = sbox_q;
        out_d   = out_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                if (lastCycle) begin
                    out_d   = {chainN2[UNROLL], chainN1[UNROLL]};
                    state_d = DONE;
                end else begin
                    n1_d  = chainN1[UNROLL];
                    n2_d  = chainN2[UNROLL];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            n1_d    = bus.in_data[63:32];
            n2_d    = bus.in_data[31:0];
            mode_d  = bus.in_mode;
            key_d   = bus.in_key;
            sbox_d  = bus.in_sbox;
        end
    end

    // State registers; reset wins over a simultaneous accept and throws away
    // any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            mode_q  <= 1'b0;
            key_q   <= '0;
            sbox_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            mode_q  <= mode_d;
            key_q   <= key_d;
            sbox_q  <= sbox_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_gost89_ecb_core.sv
// ---------------------------------------------------------------------------
// tb_gost89_ecb_core
//
// Drives six gost89_ecb_core instances (UNROLL = 1, 2, 4, 8, 16, 32) from a
// shared set of input buses, with per-instance in_valid/out_ready, and
// compares every result against a behavioural GOST model.
// ---------------------------------------------------------------------------
module tb_gost89_ecb_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [5:0]         inValid;
    logic [5:0]         outReady;
    logic               inMode;
    logic [255:0]       inKey;
    logic [511:0]       inSbox;
    logic [63:0]        inData;
    logic [5:0]         inReadyV;
    logic [5:0]         outValidV;
    logic [5:0]         busyV;
    logic [5:0][63:0]   outDataV;

    int checks = 0;
    int errors = 0;
    int latency [6];

    typedef struct {
        logic [63:0]  data;
        logic         mode;
        logic [255:0] key;
        logic [63:0]  exp;
        bit           follow;
    } blk_t;

    blk_t sendQ [$];
    blk_t scoreQ [$];

    // One core per legal UNROLL value, all sharing the data-side inputs.
    for (genvar g = 0; g < 6; g++) begin : gCore
        gost89_ecb_core_if busIf ();

        assign busIf.in_valid  = inValid[g];
        assign busIf.out_ready = outReady[g];
        assign busIf.in_mode   = inMode;
        assign busIf.in_key    = inKey;
        assign busIf.in_sbox   = inSbox;
        assign busIf.in_data   = inData;
        assign inReadyV[g]     = busIf.in_ready;
        assign outValidV[g]    = busIf.out_valid;
        assign busyV[g]        = busIf.busy;
        assign outDataV[g]     = busIf.out_data;

        gost89_ecb_core #(.UNROLL(1 << g)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (busIf)
        );
    end

    // Reference model: f = S-box substitution then rotate left by 11.
    function automatic logic [31:0] refF(input logic [31:0] x, input logic [511:0] sb);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            y[4*i +: 4] = sb[64*i + 4*int'(x[4*i +: 4]) +: 4];
        end
        return (y << 11) | (y >> 21);
    endfunction

    // Reference model: full 32-round cipher using the documented key order.
    function automatic logic [63:0] refCipher(input logic [63:0] data, input logic [255:0] key,
                                              input logic [511:0] sb, input logic mode);
        logic [31:0] a, b, t, k;
        int idx;
        a = data[63:32];
        b = data[31:0];
        for (int r = 0; r < 32; r++) begin
            if ((mode == 1'b0 && r < 24) || (mode == 1'b1 && r < 8)) idx = r % 8;
            else idx = 7 - (r % 8);
            k = key[255 - 32*idx -: 32];
            t = b ^ refF(a + k, sb);
            if (r < 31) begin
                b = a;
                a = t;
            end else begin
                b = t;
            end
        end
        return {a, b};
    endfunction

    function automatic logic [255:0] randKey();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [511:0] randSbox();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] valid, input logic mode, input logic [63:0] data,
                                 input logic [255:0] key, input logic [511:0] sbox);
        inValid = valid;
        inMode  = mode;
        inData  = data;
        inKey   = key;
        inSbox  = sbox;
    endtask

    // Counts cycles after an accept edge until each core shows out_valid,
    // and tracks that every presented result stays at the expected value.
    task automatic measureLatency(input string tag, input logic [63:0] expVal, input int budget);
        logic [5:0] unstable;
        unstable = '0;
        for (int k = 0; k < 6; k++) latency[k] = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 6; k++) begin
                if (outValidV[k] && latency[k] == 0) latency[k] = c;
                if (latency[k] != 0 && outDataV[k] !== expVal) unstable[k] = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("%s_latency_u%0d", tag, 1 << k), 64'(latency[k]), 64'(32 >> k));
            checkOutput($sformatf("%s_data_u%0d", tag, 1 << k), outDataV[k], expVal);
        end
        checkOutput({tag, "_held_stable"}, 64'(unstable), 64'h0);
        checkOutput({tag, "_in_ready_while_held"}, 64'(inReadyV), 64'h0);
        checkOutput({tag, "_out_valid_held"}, 64'(outValidV), 64'h3F);
    endtask

    logic [255:0] fixKey;
    logic [511:0] fixSbox;
    logic [63:0]  pt, ct;
    logic [255:0] key3;
    logic [511:0] sb3;
    logic [63:0]  d3, exp3;
    logic         m3;
    logic         seen;
    logic [511:0] sbox6;

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset    = 1'b1;
        inValid  = '0;
        outReady = '0;
        applyStimulus(6'h00, 1'b0, 64'h0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("reset_out_valid_u%0d", 1 << k), 64'(outValidV[k]), 64'h0);
            checkOutput($sformatf("reset_busy_u%0d", 1 << k), 64'(busyV[k]), 64'h0);
            checkOutput($sformatf("reset_in_ready_u%0d", 1 << k), 64'(inReadyV[k]), 64'h1);
            checkOutput($sformatf("reset_out_data_u%0d", 1 << k), outDataV[k], 64'h0);
        end
        reset = 1'b0;

        // Fixed-block encrypt on every UNROLL, held for a while, then
        // drained while the decrypt of the ciphertext is accepted on the
        // same edge.
        fixKey  = randKey();
        fixSbox = randSbox();
        pt      = 64'h0123456789ABCDEF;
        ct      = refCipher(pt, fixKey, fixSbox, 1'b0);
        @(negedge clk);
        applyStimulus(6'h3F, 1'b0, pt, fixKey, fixSbox);
        outReady = '0;
        @(posedge clk);
        #1;
        inValid = '0;
        checkOutput("enc_busy_after_accept", 64'(busyV), 64'h3F);
        measureLatency("enc", ct, 45);

        @(negedge clk);
        applyStimulus(6'h3F, 1'b1, ct, fixKey, fixSbox);
        outReady = 6'h3F;
        #1;
        checkOutput("drain_in_ready", 64'(inReadyV), 64'h3F);
        @(posedge clk);
        #1;
        inValid  = '0;
        outReady = '0;
        checkOutput("reload_out_valid_low", 64'(outValidV), 64'h0);
        checkOutput("reload_busy", 64'(busyV), 64'h3F);
        measureLatency("dec", pt, 45);

        @(negedge clk);
        outReady = 6'h3F;
        @(posedge clk);
        #1;
        outReady = '0;
        checkOutput("drain_idle_out_valid", 64'(outValidV), 64'h0);
        checkOutput("drain_idle_in_ready", 64'(inReadyV), 64'h3F);

        // Inputs scrambled every cycle while the UNROLL=1 core runs.
        key3 = randKey();
        sb3  = randSbox();
        d3   = {$urandom, $urandom};
        m3   = 1'($urandom_range(0, 1));
        exp3 = refCipher(d3, key3, sb3, m3);
        @(negedge clk);
        applyStimulus(6'h01, m3, d3, key3, sb3);
        @(posedge clk);
        #1;
        inValid = '0;
        seen    = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            applyStimulus(6'h00, 1'($urandom_range(0, 1)), {$urandom, $urandom}, randKey(), randSbox());
            @(posedge clk);
            #1;
            seen = outValidV[0];
        end
        checkOutput("latched_result_seen", 64'(seen), 64'h1);
        checkOutput("latched_result_data", outDataV[0], exp3);
        @(negedge clk);
        outReady = 6'h01;
        @(posedge clk);
        #1;
        outReady = '0;

        // Reset in the middle of a run discards the block.
        @(negedge clk);
        applyStimulus(6'h01, 1'b0, pt, fixKey, fixSbox);
        @(posedge clk);
        #1;
        inValid = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun_reset_out_valid", 64'(outValidV[0]), 64'h0);
        checkOutput("midrun_reset_busy", 64'(busyV[0]), 64'h0);
        checkOutput("midrun_reset_in_ready", 64'(inReadyV[0]), 64'h1);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= outValidV[0];
        end
        checkOutput("midrun_reset_no_result", 64'(seen), 64'h0);

        // Reset together with an offered block: nothing is accepted.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(6'h01, 1'b0, pt, fixKey, fixSbox);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        inValid = '0;
        checkOutput("reset_accept_busy", 64'(busyV[0]), 64'h0);
        checkOutput("reset_accept_in_ready", 64'(inReadyV[0]), 64'h1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= outValidV[0];
        end
        checkOutput("reset_accept_no_result", 64'(seen), 64'h0);

        // Random stream on the UNROLL=4 core. Every result that comes back
        // is turned round in the opposite direction and must restore the
        // original block.
        begin
            int   sent;
            int   got;
            int   guard;
            bit   offering;
            blk_t cur;
            blk_t res;
            blk_t fol;
            sent     = 0;
            got      = 0;
            guard    = 0;
            offering = 0;
            sbox6    = randSbox();
            while (got < 1000 && guard < 60000) begin
                @(negedge clk);
                guard++;
                if (!offering && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    if (sendQ.size() > 0) begin
                        cur = sendQ.pop_front();
                    end else begin
                        cur.data   = {$urandom, $urandom};
                        cur.mode   = 1'($urandom_range(0, 1));
                        cur.key    = randKey();
                        cur.exp    = refCipher(cur.data, cur.key, sbox6, cur.mode);
                        cur.follow = 0;
                    end
                    offering = 1;
                end
                if (offering) applyStimulus(6'b000100, cur.mode, cur.data, cur.key, sbox6);
                else inValid = '0;
                outReady = {3'b000, 1'($urandom_range(0, 2) != 0), 2'b00};
                #1;
                if (outValidV[2] && outReady[2]) begin
                    if (scoreQ.size() == 0) begin
                        checkOutput("stream_unexpected_result", 64'h1, 64'h0);
                    end else begin
                        res = scoreQ.pop_front();
                        checkOutput(res.follow ? "stream_roundtrip" : "stream_model", outDataV[2], res.exp);
                        got++;
                        if (!res.follow) begin
                            fol.data   = outDataV[2];
                            fol.mode   = ~res.mode;
                            fol.key    = res.key;
                            fol.exp    = res.data;
                            fol.follow = 1;
                            sendQ.push_back(fol);
                        end
                    end
                end
                if (inValid[2] && inReadyV[2]) begin
                    scoreQ.push_back(cur);
                    offering = 0;
                    sent++;
                end
            end
            inValid  = '0;
            outReady = '0;
            checkOutput("stream_results_received", 64'(got), 64'd1000);
            checkOutput("stream_scoreboard_empty", 64'(scoreQ.size()), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
